// File: rtl/fastica_pkg.sv
// Shared defaults and FSM state encoding for the channel-mean calculator.
package fastica_pkg;

   localparam int DATA_W_DEF      = 16;
   localparam int N_CH_DEF        = 4;
   localparam int N_SAMP_LOG2_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } mean_state_t;

   // Accumulator width that can absorb 2^n_samp_log2 full-scale samples.
   function automatic int acc_width(input int data_w, input int n_samp_log2);
      return data_w + n_samp_log2;
   endfunction

endpackage

// File: rtl/mean_acc_lane.sv
// Single-channel sample accumulator with arithmetic-shift (or round-half-up) mean output.
// Optional feature: define MEAN_ROUND_EN for round-half-up instead of floor.
module mean_acc_lane
   import fastica_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int N_SAMP_LOG2 = N_SAMP_LOG2_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              add,
   input  logic              last,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] mean
);

   localparam int ACC_W = acc_width(DATA_W, N_SAMP_LOG2);

   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] sum_next;
   logic signed [ACC_W-1:0] rounded;
   logic                    frac_unused;

   assign sample_ext = {{N_SAMP_LOG2{sample[DATA_W-1]}}, sample};

   // The first sample of a run replaces the old total instead of adding to it.
   assign sum_next = load ? sample_ext : (acc_reg + sample_ext);

`ifdef MEAN_ROUND_EN
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (N_SAMP_LOG2 - 1);
   // Cannot overflow: the largest total is 2^N_SAMP_LOG2 below the positive limit.
   assign rounded = sum_next + HALF;
`else
   assign rounded = sum_next;
`endif

   assign frac_unused = ^rounded[N_SAMP_LOG2-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         mean    <= '0;
      end else begin
         if (load || add) begin
            acc_reg <= sum_next;
         end
         if (last) begin
            mean <= rounded[ACC_W-1:N_SAMP_LOG2];
         end
      end
   end

endmodule

// File: rtl/mean_calc.sv
// Per-channel mean over 2^N_SAMP_LOG2 accepted samples, one lane per channel.
// Optional feature: MEAN_ROUND_EN selects round-half-up means (default is floor).
module mean_calc
   import fastica_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int N_CH        = N_CH_DEF,
   parameter int N_SAMP_LOG2 = N_SAMP_LOG2_DEF
) (
   input  logic                     clk_mean,
   input  logic                     go_fast,
   input  logic                     en_mean,
   input  logic [N_CH*DATA_W-1:0]   data_in,
   output logic [N_CH*DATA_W-1:0]   mean_out,
   output logic                     mean_valid,
   output logic                     mean_busy,
   output logic [N_SAMP_LOG2:0]     sample_cnt
);

   localparam int               CNT_W    = N_SAMP_LOG2 + 1;
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(1) << N_SAMP_LOG2;
   localparam logic [CNT_W-1:0] LAST_PRE = FULL - CNT_W'(1);

   mean_state_t state_reg;
   logic        accept_first;
   logic        accept_more;
   logic        last_sample;

   assign accept_first = (state_reg == IDLE) && en_mean;
   assign accept_more  = (state_reg == ACC) && en_mean;
   assign last_sample  = accept_more && (sample_cnt == LAST_PRE);

   always_ff @(posedge clk_mean or negedge go_fast) begin
      if (!go_fast) begin
         state_reg  <= IDLE;
         sample_cnt <= '0;
         mean_valid <= 1'b0;
         mean_busy  <= 1'b0;
      end else begin
         mean_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (en_mean) begin
                  state_reg  <= ACC;
                  sample_cnt <= CNT_W'(1);
                  mean_busy  <= 1'b1;
               end
            end
            ACC: begin
               if (en_mean) begin
                  sample_cnt <= sample_cnt + CNT_W'(1);
                  if (sample_cnt == LAST_PRE) begin
                     state_reg  <= DONE;
                     mean_busy  <= 1'b0;
                     mean_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               // Stay here while the controller keeps en_mean high; a low cycle re-arms.
               if (!en_mean) begin
                  state_reg  <= IDLE;
                  sample_cnt <= '0;
               end
            end
            default: begin
               state_reg  <= IDLE;
               sample_cnt <= '0;
               mean_busy  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      mean_acc_lane #(
         .DATA_W      (DATA_W),
         .N_SAMP_LOG2 (N_SAMP_LOG2)
      ) u_lane (
         .clk    (clk_mean),
         .rst_n  (go_fast),
         .load   (accept_first),
         .add    (accept_more),
         .last   (last_sample),
         .sample (data_in[gi*DATA_W +: DATA_W]),
         .mean   (mean_out[gi*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_mean_calc.sv
// Randomised scoreboard bench for mean_calc; expected means come from plain integer arithmetic.
module tb_mean_calc;

   localparam int DW  = 16;
   localparam int NC  = 4;
   localparam int NSL = 7;
   localparam int NS  = 128;
`ifdef MEAN_ROUND_EN
   localparam longint ROUND_ADD = 64;
`else
   localparam longint ROUND_ADD = 0;
`endif

   logic                 clk_mean = 1'b0;
   logic                 go_fast;
   logic                 en_mean;
   logic [NC*DW-1:0]     data_in;
   logic [NC*DW-1:0]     mean_out;
   logic                 mean_valid;
   logic                 mean_busy;
   logic [NSL:0]         sample_cnt;

   mean_calc #(.DATA_W(DW), .N_CH(NC), .N_SAMP_LOG2(NSL)) dut (
      .clk_mean   (clk_mean),
      .go_fast    (go_fast),
      .en_mean    (en_mean),
      .data_in    (data_in),
      .mean_out   (mean_out),
      .mean_valid (mean_valid),
      .mean_busy  (mean_busy),
      .sample_cnt (sample_cnt)
   );

   always #5 clk_mean = ~clk_mean;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference: a run is a list of accepted samples; its mean is sum/128.
   logic [NC*DW-1:0] exp_q[$];
   longint           msum[NC];
   int               mcnt = 0;
   bit               mdone = 1'b0;
   bit               exp_valid = 1'b0;
   logic [NC*DW-1:0] last_mean = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic logic [NC*DW-1:0] pack_all(input logic [DW-1:0] v);
      logic [NC*DW-1:0] p;
      for (int k = 0; k < NC; k++) p[k*DW +: DW] = v;
      return p;
   endfunction

   function automatic logic [NC*DW-1:0] rand_data();
      return {$urandom, $urandom};
   endfunction

   task automatic model_step(input bit en, input logic [NC*DW-1:0] d);
      logic [NC*DW-1:0] pm;
      longint           m;
      exp_valid = 1'b0;
      if (mdone) begin
         if (!en) begin
            mdone = 1'b0;
            mcnt  = 0;
         end
      end else if (en) begin
         if (mcnt == 0) begin
            for (int k = 0; k < NC; k++) msum[k] = 0;
         end
         for (int k = 0; k < NC; k++) msum[k] += longint'($signed(d[k*DW +: DW]));
         mcnt++;
         if (mcnt == NS) begin
            for (int k = 0; k < NC; k++) begin
               m = floor_div(msum[k] + ROUND_ADD, NS);
               pm[k*DW +: DW] = m[DW-1:0];
            end
            exp_q.push_back(pm);
            last_mean = pm;
            exp_valid = 1'b1;
            mdone     = 1'b1;
         end
      end
   endtask

   // One clock cycle: apply inputs, let the edge happen, check registered outputs on the falling edge.
   task automatic drive(input bit en, input logic [NC*DW-1:0] d);
      en_mean = en;
      data_in = d;
      @(posedge clk_mean);
      model_step(en, d);
      @(negedge clk_mean);
      chk("sample_cnt", 64'(sample_cnt), 64'(mcnt));
      chk("mean_busy", 64'(mean_busy), 64'(!mdone && mcnt > 0));
      chk("mean_valid", 64'(mean_valid), 64'(exp_valid));
      chk("mean_out_hold", mean_out, last_mean);
   endtask

   task automatic pulse_reset();
      en_mean = 1'b0;
      go_fast = 1'b0;
      #1;
      chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
      chk("rst_busy", 64'(mean_busy), 64'd0);
      chk("rst_valid", 64'(mean_valid), 64'd0);
      chk("rst_mean_out", mean_out, 64'd0);
      mcnt = 0;
      mdone = 1'b0;
      last_mean = '0;
      @(posedge clk_mean);
      @(negedge clk_mean);
      go_fast = 1'b1;
   endtask

   // Scoreboard monitor: every mean_valid pulse must match the oldest expected mean.
   always @(negedge clk_mean) begin
      if (mean_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
         end else begin
            chk("sb_mean", mean_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [NC*DW-1:0] d;
      logic [DW-1:0]    ch0;
      int               guard;

      go_fast = 1'b0;
      en_mean = 1'b0;
      data_in = '0;
      repeat (2) @(posedge clk_mean);
      @(negedge clk_mean);
      chk("reset_cnt", 64'(sample_cnt), 64'd0);
      chk("reset_busy", 64'(mean_busy), 64'd0);
      chk("reset_valid", 64'(mean_valid), 64'd0);
      chk("reset_mean", mean_out, 64'd0);
      go_fast = 1'b1;
      drive(1'b0, '0);

      // Constant +100 on every channel.
      for (int i = 0; i < NS; i++) drive(1'b1, pack_all(16'd100));
      chk("const100_mean", mean_out, pack_all(16'd100));
      chk("const100_cnt", 64'(sample_cnt), 64'd128);
      drive(1'b0, rand_data());
      drive(1'b0, rand_data());

      // Channel 0 alternates +1/0 (sum 64); other channels random.
      for (int i = 0; i < NS; i++) begin
         d = rand_data();
         d[DW-1:0] = (i % 2 == 0) ? 16'd1 : 16'd0;
         drive(1'b1, d);
      end
      ch0 = mean_out[DW-1:0];
`ifdef MEAN_ROUND_EN
      chk("alt_ch0_round", 64'(ch0), 64'd1);
`else
      chk("alt_ch0_floor", 64'(ch0), 64'd0);
`endif
      drive(1'b0, rand_data());

      // Full-scale extremes must not wrap.
      for (int i = 0; i < NS; i++) drive(1'b1, pack_all(16'h8000));
      chk("neg_full", mean_out, pack_all(16'h8000));
      drive(1'b0, rand_data());
      for (int i = 0; i < NS; i++) drive(1'b1, pack_all(16'h7fff));
      chk("pos_full", mean_out, pack_all(16'h7fff));
      drive(1'b0, rand_data());

      // Pause in the middle of a run.
      for (int i = 0; i < 64; i++) drive(1'b1, rand_data());
      for (int i = 0; i < 10; i++) drive(1'b0, rand_data());
      for (int i = 0; i < 64; i++) drive(1'b1, rand_data());
      drive(1'b0, rand_data());

      // Enable held through 130 cycles, then an independent second run.
      for (int i = 0; i < 130; i++) drive(1'b1, rand_data());
      drive(1'b0, rand_data());
      for (int i = 0; i < NS; i++) drive(1'b1, rand_data());
      drive(1'b0, rand_data());

      // Reset after 50 samples, then a clean run.
      for (int i = 0; i < 50; i++) drive(1'b1, rand_data());
      pulse_reset();
      for (int i = 0; i < NS; i++) drive(1'b1, rand_data());
      drive(1'b0, rand_data());

      // Random enable pattern, several runs.
      for (int r = 0; r < 4; r++) begin
         guard = 0;
         while (!mdone && guard < 1000) begin
            drive(($urandom_range(0, 9) < 7), rand_data());
            guard++;
         end
         chk("random_run_done", 64'(mdone), 64'd1);
         repeat ($urandom_range(1, 3)) drive(1'b0, rand_data());
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
